uart_rx_os: RTL
===============

Name: uart_rx_os

Overview:
Parametrised oversampling UART receiver with an integrated receive FIFO. It is the successor to the fixed-format receive path behind the APB UART top.
- Adds runtime frame format: 5–8 data bits, none/even/odd parity, 1 or 2 stop bits.
- Adds majority-vote sampling, per-entry error flags, overrun tracking and a threshold interrupt.
- Sits between the rx pin and the APB register file, which drives the config inputs and pops entries.

Parameters:
OVERSAMPLE, 16, baud ticks per bit (even, >=8)
FIFO_DEPTH, 8, receive FIFO entries (power of two, >=2)
CLK_DIV_W, 16, width of baud divider

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
baud_div  in  CLK_DIV_W  clk cycles per oversample tick minus 1
data_bits  in  2  00=5, 01=6, 10=7, 11=8 data bits
parity_en  in  1  parity bit present
parity_odd  in  1  1=odd, 0=even parity
two_stop  in  1  two stop bits
rx  in  1  asynchronous serial input, idle high
rd_en  in  1  pop head entry
rd_data  out  10  {frame_err, parity_err, data[7:0]} of head entry
empty  out  1  FIFO empty
full  out  1  FIFO full
count  out  $clog2(FIFO_DEPTH+1)  entries held
rx_thresh  in  $clog2(FIFO_DEPTH+1)  interrupt level
overrun  out  1  sticky: frame dropped due to full FIFO
clr_overrun  in  1  clears overrun
irq  out  1  registered level: (count>=rx_thresh && rx_thresh!=0) || overrun

Behaviour:
- Reset values:
  - Synchroniser flops = 1; state = IDLE; FIFO pointers and count = 0.
  - empty=1, full=0, overrun=0, irq=0, rd_data=0.
- Input sync and baud tick:
  - rx passes through a 2-flop synchroniser; all logic uses rx_s.
  - The tick counter counts 0..baud_div and pulses tick for one clk at the terminal count, then wraps to 0.
  - baud_div=0 gives a tick every clk.
- Sampling:
  - The sample counter runs 0..OVERSAMPLE-1 per bit.
  - The bit value is the majority of rx_s at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The decision takes effect at tick OVERSAMPLE/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK_WAIT.
  - IDLE: on rx_s==0, latch the config inputs into frame registers, clear counters and enter START. Config changes mid-frame do not affect the current frame.
  - START: a majority of 1 is a false start, return to IDLE with no push. A majority of 0 enters DATA.
  - DATA: shift bits in LSB first, data right-aligned, unused upper bits 0. After N bits go to PARITY if parity_en, else STOP1.
  - PARITY: parity_err = (XOR of data bits ^ parity bit) != parity_odd.
  - STOP1: a sampled 0 sets frame_err. If two_stop and no error so far, go to STOP2; otherwise push.
  - STOP2: sampled 0 sets frame_err, then push.
  - After push: if rx_s==0 and frame_err, go to BREAK_WAIT, otherwise IDLE. The FSM leaves at mid-stop, so back-to-back frames are caught.
  - BREAK_WAIT: stay until rx_s==1, then IDLE. A break yields exactly one entry.
- Push:
  - Asserted for one clk on the cycle after the deciding tick of the last stop bit.
  - count updates on the following clk edge.
- FIFO:
  - Show-ahead: rd_data reflects the head entry combinationally and is 0 when empty.
  - rd_en while empty is ignored.
  - Push while full drops the frame and sets overrun, except when rd_en is in the same cycle: then pop and push both occur and count is unchanged.
  - Push and pop together when not full leave count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - overrun set and clr_overrun in the same cycle: set wins.
- Reset mid-frame: the partial frame is discarded and the FIFO is emptied immediately (async).

Decomposition:
- Package uart_rx_pkg:
  - rx_state_e enum.
  - rx_entry_t struct {frame_err, parity_err, data[7:0]}.
  - data_bits encoding constants.
  - MAJ_LO/MAJ_HI offset function of OVERSAMPLE.
- Sub-module uart_sync_fifo, parametrised on DEPTH and entry type, owning pointers, count, full/empty and the simultaneous push/pop rules.
- The FSM, tick generator and synchroniser stay in uart_rx_os.

Test Plan:
1. baud_div=0, 8N1, send 0xA5 → one entry, rd_data=10'h0A5, count=1, empty=0 about 152 clk after the start edge; rd_en → empty=1, rd_data=0.
2. 7E1, send 0x3A with parity bit 1 (wrong) → rd_data={0,1,7'h3A}, i.e. 10'h13A; repeat with parity 0 → 10'h03A. 5O2, send 0x15 → 10'h015.
3. rx low for 4 clk then high (baud_div=0) → no push, count stays 0, FSM back in IDLE; a following valid 0x55 is received as 10'h055.
4. rx held low for 20 bit times at 8N1 → exactly one entry 10'h200 (frame_err, data 0); no further entries until rx rises; the next 0x81 is received correctly.
5. FIFO_DEPTH=8, rx_thresh=4, nine back-to-back 8N1 frames, no reads:
   - irq rises when count=4.
   - After frame 8, count=8 and full=1; frame 9 is dropped and overrun=1.
   - clr_overrun → overrun=0; irq stays 1.
6. Assert rst mid-DATA with 3 entries queued → outputs return to reset values immediately; after deassert, 0xC3 is received as 10'h0C3 with count=1.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_BREAK
  } rx_state_e;

  typedef struct packed {
    logic       frame_err;
    logic       parity_err;
    logic [7:0] data;
  } rx_entry_t;

  localparam logic [1:0] DB_5 = 2'b00;
  localparam logic [1:0] DB_6 = 2'b01;
  localparam logic [1:0] DB_7 = 2'b10;
  localparam logic [1:0] DB_8 = 2'b11;

  function automatic int maj_lo(input int os);
    return os / 2 - 1;
  endfunction

  function automatic int maj_hi(input int os);
    return os / 2 + 1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead receive FIFO; a push into a full FIFO is dropped
// unless a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic [9:0]
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  T                           wdata_i,
  output T                           rdata_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       drop_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  T                mem_q [DEPTH];
  logic [PW-1:0]   wr_q;
  logic [PW-1:0]   rd_q;
  logic [CW-1:0]   cnt_q;
  logic            do_pop;
  logic            do_push;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && !do_push;

  always_comb begin
    rdata_o = '0;
    if (!empty_o) rdata_o = mem_q[rd_q];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: runtime frame format, majority-vote
// sampling, error flags per entry, overrun and threshold interrupt.
module uart_rx_os
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV_W  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CLK_DIV_W-1:0]            baud_div,
  input  logic [1:0]                      data_bits,
  input  logic                            parity_en,
  input  logic                            parity_odd,
  input  logic                            two_stop,
  input  logic                            rx,
  input  logic                            rd_en,
  output logic [9:0]                      rd_data,
  output logic                            empty,
  output logic                            full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  input  logic [$clog2(FIFO_DEPTH+1)-1:0] rx_thresh,
  output logic                            overrun,
  input  logic                            clr_overrun,
  output logic                            irq
);

  localparam int SC_W = $clog2(OVERSAMPLE);
  localparam logic [SC_W-1:0] S_LO  = SC_W'(maj_lo(OVERSAMPLE));
  localparam logic [SC_W-1:0] S_MID = SC_W'(OVERSAMPLE / 2);
  localparam logic [SC_W-1:0] S_HI  = SC_W'(maj_hi(OVERSAMPLE));
  localparam logic [SC_W-1:0] S_END = SC_W'(OVERSAMPLE - 1);

  logic                 s1_q, s2_q, rx_s;
  logic [CLK_DIV_W-1:0] div_q;
  logic                 tick;
  rx_state_e            state_q;
  logic [SC_W-1:0]      sc_q;
  logic [2:0]           bc_q;
  logic [1:0]           smp_q;
  logic [7:0]           data_q;
  logic                 perr_q, ferr_q, push_q;
  logic [1:0]           db_q;
  logic                 pen_q, podd_q, two_q;
  logic                 bit_maj;
  logic [2:0]           last_bit;
  rx_entry_t            entry, head;
  logic                 drop;
  logic                 overrun_q, irq_q;

  assign rx_s     = s2_q;
  assign tick     = (div_q >= baud_div);
  assign bit_maj  = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
  assign last_bit = {1'b0, db_q} + 3'd4;
  assign entry    = {ferr_q, perr_q, data_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= 1'b1;
      s2_q  <= 1'b1;
      div_q <= '0;
    end else begin
      s1_q  <= rx;
      s2_q  <= s1_q;
      div_q <= tick ? '0 : div_q + CLK_DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sc_q    <= '0;
      bc_q    <= '0;
      smp_q   <= 2'b11;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      push_q  <= 1'b0;
      db_q    <= DB_8;
      pen_q   <= 1'b0;
      podd_q  <= 1'b0;
      two_q   <= 1'b0;
    end else begin
      push_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            db_q    <= data_bits;
            pen_q   <= parity_en;
            podd_q  <= parity_odd;
            two_q   <= two_stop;
            sc_q    <= '0;
            bc_q    <= '0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            state_q <= ST_START;
          end
        end
        ST_BREAK: begin
          if (rx_s) state_q <= ST_IDLE;
        end
        default: begin
          if (tick) begin
            sc_q <= (sc_q == S_END) ? '0 : sc_q + SC_W'(1);
            if (sc_q == S_LO)  smp_q[0] <= rx_s;
            if (sc_q == S_MID) smp_q[1] <= rx_s;
            // Leaving at mid-stop lets a back-to-back start edge be seen.
            if (sc_q == S_HI) begin
              unique case (state_q)
                ST_START: state_q <= bit_maj ? ST_IDLE : ST_DATA;
                ST_DATA: begin
                  data_q[bc_q] <= bit_maj;
                  bc_q         <= bc_q + 3'd1;
                  if (bc_q == last_bit)
                    state_q <= pen_q ? ST_PARITY : ST_STOP1;
                end
                ST_PARITY: begin
                  perr_q  <= ((^data_q) ^ bit_maj) != podd_q;
                  state_q <= ST_STOP1;
                end
                ST_STOP1: begin
                  ferr_q <= !bit_maj;
                  if (two_q && bit_maj) begin
                    state_q <= ST_STOP2;
                  end else begin
                    push_q  <= 1'b1;
                    state_q <= (!rx_s && !bit_maj) ? ST_BREAK : ST_IDLE;
                  end
                end
                ST_STOP2: begin
                  ferr_q  <= ferr_q | !bit_maj;
                  push_q  <= 1'b1;
                  state_q <= (!rx_s && !bit_maj) ? ST_BREAK : ST_IDLE;
                end
                default: state_q <= ST_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (rx_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_q),
    .pop_i   (rd_en),
    .wdata_i (entry),
    .rdata_o (head),
    .empty_o (empty),
    .full_o  (full),
    .drop_o  (drop),
    .count_o (count)
  );

  assign rd_data = head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (drop)             overrun_q <= 1'b1;
      else if (clr_overrun) overrun_q <= 1'b0;
      irq_q <= ((count >= rx_thresh) && (rx_thresh != '0)) || overrun_q;
    end
  end

  assign overrun = overrun_q;
  assign irq     = irq_q;

endmodule
